// File: rtl/allocator.sv
// Slot-ownership bookkeeper: hands out the lowest free slot on alloc and
// releases slots oldest-first on dealloc, tracked by a circular age list.
module allocator #(
  parameter int NUM_Q = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic             dealloc,
  output logic [NUM_Q-1:0] QValid
);

  localparam int IDX_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam int CNT_W = IDX_W + 1;

  logic [NUM_Q-1:0] valid_q, valid_d;
  logic [IDX_W-1:0] age_q [NUM_Q];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] free_idx;
  logic             do_alloc;
  logic             do_dealloc;

  // Pointers wrap explicitly so non-power-of-two slot counts stay correct.
  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    if (p == IDX_W'(NUM_Q - 1)) return '0;
    return p + IDX_W'(1);
  endfunction

  always_comb begin
    free_idx = '0;
    // Scan high-to-low so the last match left standing is the lowest free slot.
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Both requests are judged against the pre-edge state, so a slot freed
  // this cycle is never the alloc target in the same cycle.
  assign do_alloc   = alloc && !(&valid_q);
  assign do_dealloc = dealloc && (cnt_q != '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    if (do_dealloc) begin
      valid_d[age_q[head_q]] = 1'b0;
      head_d                 = ptr_inc(head_q);
    end
    if (do_alloc) begin
      valid_d[free_idx] = 1'b1;
      tail_d            = ptr_inc(tail_q);
    end
    case ({do_alloc, do_dealloc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the age storage is deliberately not reset; entries are only read
  // between head and tail, which reset already makes empty.
  always_ff @(posedge clk) begin
    if (!rst && do_alloc) age_q[tail_q] <= free_idx;
  end

  assign QValid = valid_q;

endmodule

// File: tb/tb_allocator.sv
// Directed bench for allocator: a vector table of per-cycle requests with
// hand-computed QValid, plus hand-written reset sequences.
module tb_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc;
  logic       dealloc;
  logic [3:0] QValid;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       alloc;
    logic       dealloc;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  allocator #(.NUM_Q(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .alloc  (alloc),
    .dealloc(dealloc),
    .QValid (QValid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: QValid=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic r, input logic a, input logic d,
                     input logic [3:0] exp);
    vec_t v;
    v.name = name; v.rst = r; v.alloc = a; v.dealloc = d; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic step(input string name, input logic r, input logic a, input logic d,
                      input logic [3:0] exp);
    @(negedge clk);
    rst = r; alloc = a; dealloc = d;
    @(posedge clk);
    #1;
    check(name, QValid, exp);
  endtask

  initial begin
    rst = 1'b0; alloc = 1'b0; dealloc = 1'b0;

    // Reset held for 10 cycles with no requests.
    for (int i = 0; i < 10; i++) step($sformatf("reset_hold%0d", i), 1'b1, 1'b0, 1'b0, 4'b0000);

    // Fill, overflow, refill slot 0, then drain in age order (1,2,3,0).
    add("fill0",     0, 1, 0, 4'b0001);
    add("fill1",     0, 1, 0, 4'b0011);
    add("fill2",     0, 1, 0, 4'b0111);
    add("fill3",     0, 1, 0, 4'b1111);
    add("ovf0",      0, 1, 0, 4'b1111);
    add("ovf1",      0, 1, 0, 4'b1111);
    add("ovf_free0", 0, 0, 1, 4'b1110);
    add("refill0",   0, 1, 0, 4'b1111);
    add("drain_s1",  0, 0, 1, 4'b1101);
    add("drain_s2",  0, 0, 1, 4'b1001);
    add("drain_s3",  0, 0, 1, 4'b0001);
    add("drain_s0",  0, 0, 1, 4'b0000);
    add("undf",      0, 0, 1, 4'b0000);
    // Reuse: slot 0 becomes the youngest allocation.
    add("reuse_a0",  0, 1, 0, 4'b0001);
    add("reuse_a1",  0, 1, 0, 4'b0011);
    add("reuse_a2",  0, 1, 0, 4'b0111);
    add("reuse_d0",  0, 0, 1, 4'b0110);
    add("reuse_a0b", 0, 1, 0, 4'b0111);
    add("reuse_d1",  0, 0, 1, 4'b0101);
    add("reuse_d2",  0, 0, 1, 4'b0001);
    add("reuse_d0b", 0, 0, 1, 4'b0000);
    // Simultaneous alloc+dealloc.
    add("sim_a0",    0, 1, 0, 4'b0001);
    add("sim_a1",    0, 1, 0, 4'b0011);
    add("sim_0011",  0, 1, 1, 4'b0110);
    add("sim_a0b",   0, 1, 0, 4'b0111);
    add("sim_a3",    0, 1, 0, 4'b1111);
    add("sim_full1", 0, 1, 1, 4'b1101);
    add("sim_1101",  0, 1, 1, 4'b1011);
    add("sim_dr0",   0, 0, 1, 4'b1010);
    add("sim_dr3",   0, 0, 1, 4'b0010);
    add("sim_dr1",   0, 0, 1, 4'b0000);
    add("sim_empty", 0, 1, 1, 4'b0001);
    // Full with slot 0 oldest: simultaneous request frees slot 0 only.
    add("sim_rst",   1, 0, 0, 4'b0000);
    add("sim_f0",    0, 1, 0, 4'b0001);
    add("sim_f1",    0, 1, 0, 4'b0011);
    add("sim_f2",    0, 1, 0, 4'b0111);
    add("sim_f3",    0, 1, 0, 4'b1111);
    add("sim_full0", 0, 1, 1, 4'b1110);

    foreach (vecs[i]) step(vecs[i].name, vecs[i].rst, vecs[i].alloc, vecs[i].dealloc, vecs[i].exp);

    // Reset overriding an alloc at 0111, then a fresh alloc.
    step("mr_rst",   1'b1, 1'b0, 1'b0, 4'b0000);
    step("mr_a0",    1'b0, 1'b1, 1'b0, 4'b0001);
    step("mr_a1",    1'b0, 1'b1, 1'b0, 4'b0011);
    step("mr_a2",    1'b0, 1'b1, 1'b0, 4'b0111);
    step("mr_rstal", 1'b1, 1'b1, 1'b0, 4'b0000);
    step("mr_after", 1'b0, 1'b1, 1'b0, 4'b0001);

    // Reset overriding alloc+dealloc; the age list must restart empty.
    step("mr2_a1",   1'b0, 1'b1, 1'b0, 4'b0011);
    step("mr2_rst",  1'b1, 1'b1, 1'b1, 4'b0000);
    step("mr2_d",    1'b0, 1'b0, 1'b1, 4'b0000);
    step("mr2_a0",   1'b0, 1'b1, 1'b0, 4'b0001);
    step("mr2_a1b",  1'b0, 1'b1, 1'b0, 4'b0011);
    step("mr2_d0",   1'b0, 1'b0, 1'b1, 4'b0010);
    step("mr2_hold", 1'b0, 1'b0, 1'b0, 4'b0010);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
